// File: rtl/dma_burst_sequencer_pkg.sv
// dma_burst_sequencer_pkg: op codes, sequencer states, per-op base addresses and burst sizing
package dma_burst_sequencer_pkg;
    typedef enum logic [2:0] {
        OP_INF = 3'd0,
        OP_FMI = 3'd1,
        OP_KEX = 3'd2,
        OP_KPW = 3'd3,
        OP_KDW = 3'd4,
        OP_FMO = 3'd5
    } dma_op_t;
    typedef enum logic [2:0] {IDLE, DECODE, REQ, WAIT, DONE} dma_seq_state_t;
    localparam logic [31:0] BASE_ADDR [8] = '{
        32'h0000_1000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
        32'h0004_0000, 32'h0008_0000, 32'h0000_0000, 32'h0000_0000
    };
    function automatic logic [15:0] burst_len(input logic [15:0] rem, input int max_burst);
        return (rem < 16'(max_burst)) ? rem : 16'(max_burst);
    endfunction
endpackage

// File: rtl/dma_burst_sequencer_dma_op_decode.sv
// dma_op_decode: maps a latched DMA command onto base address, row count, row length and direction
module dma_op_decode
    import dma_burst_sequencer_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int INF_WORDS = 2
) (
    input  logic [2:0]        i_op,
    input  logic [15:0]       i_info1,
    input  logic [7:0]        i_info2,
    input  logic [31:0]       i_mem_info1,
    input  logic [31:0]       i_mem_info2,
    output logic [ADDR_W-1:0] o_base,
    output logic [7:0]        o_rows,
    output logic [15:0]       o_row_len,
    output logic              o_we,
    output logic              o_illegal
);
    logic w_row_op;
    assign w_row_op  = (i_op == OP_FMI) || (i_op == OP_FMO);
    assign o_base    = ADDR_W'(BASE_ADDR[i_op]) + ADDR_W'(i_mem_info1) + ADDR_W'(i_mem_info2);
    assign o_rows    = w_row_op ? i_info2 : 8'd1;
    assign o_row_len = (i_op == OP_INF) ? 16'(INF_WORDS) : w_row_op ? {8'd0, i_info1[7:0]} : i_info1;
    assign o_we      = i_op == OP_FMO;
    assign o_illegal = i_op > OP_FMO;
endmodule

// File: rtl/dma_burst_sequencer.sv
// dma_burst_sequencer: splits one DMA command into row/segment memory bursts and pulses f_dma when done
module dma_burst_sequencer
    import dma_burst_sequencer_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int MAX_BURST  = 16,
    parameter int ROW_STRIDE = 64,
    parameter int INF_WORDS  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_s_dma,
    input  logic [2:0]        i_dma_op,
    input  logic [31:0]       i_dma_info1,
    input  logic [31:0]       i_dma_info2,
    input  logic [31:0]       i_dma_mem_info1,
    input  logic [31:0]       i_dma_mem_info2,
    output logic              o_f_dma,
    output logic              o_busy,
    output logic              o_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_len,
    input  logic              i_mem_gnt,
    input  logic              i_mem_done
);
    dma_seq_state_t    r_state, w_next;
    logic [2:0]        r_op;
    logic [15:0]       r_info1;
    logic [7:0]        r_info2;
    logic [31:0]       r_mem_info1, r_mem_info2;
    logic [ADDR_W-1:0] r_row_addr;
    logic [15:0]       r_seg_off, r_rem;
    logic [7:0]        r_row_cnt;
    logic              r_err;
    logic [ADDR_W-1:0] w_base;
    logic [7:0]        w_rows;
    logic [15:0]       w_row_len, w_len, w_rem_next;
    logic              w_we, w_illegal, w_empty, w_more_rows, w_unused;

    dma_op_decode #(.ADDR_W(ADDR_W), .INF_WORDS(INF_WORDS)) u_decode (
        .i_op        (r_op),
        .i_info1     (r_info1),
        .i_info2     (r_info2),
        .i_mem_info1 (r_mem_info1),
        .i_mem_info2 (r_mem_info2),
        .o_base      (w_base),
        .o_rows      (w_rows),
        .o_row_len   (w_row_len),
        .o_we        (w_we),
        .o_illegal   (w_illegal)
    );

    assign w_unused    = ^{i_dma_info1[31:16], i_dma_info2[31:8]};
    assign w_len       = burst_len(r_rem, MAX_BURST);
    assign w_rem_next  = r_rem - w_len;
    assign w_more_rows = ({1'b0, r_row_cnt} + 9'd1) < {1'b0, w_rows};
    assign w_empty     = w_illegal || (w_rows == 8'd0) || (w_row_len == 16'd0);
    assign o_err       = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next     = r_state;
        o_f_dma    = r_state == DONE;
        o_busy     = (r_state == DECODE) || (r_state == REQ) || (r_state == WAIT);
        o_mem_req  = r_state == REQ;
        o_mem_we   = (r_state == REQ) && w_we;
        o_mem_addr = (r_state == REQ) ? r_row_addr + ADDR_W'(r_seg_off) : '0;
        o_mem_len  = (r_state == REQ) ? w_len[7:0] : 8'd0;
        case (r_state)
            IDLE:    w_next = i_s_dma ? DECODE : IDLE;
            DECODE:  w_next = w_empty ? DONE : REQ;
            REQ:     w_next = i_mem_gnt ? WAIT : REQ;
            WAIT:    w_next = !i_mem_done ? WAIT : ((w_rem_next != 16'd0) || w_more_rows) ? REQ : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op        <= '0;
            r_info1     <= '0;
            r_info2     <= '0;
            r_mem_info1 <= '0;
            r_mem_info2 <= '0;
            r_row_addr  <= '0;
            r_seg_off   <= '0;
            r_rem       <= '0;
            r_row_cnt   <= '0;
            r_err       <= 1'b0;
        end else begin
            if ((r_state == IDLE) && i_s_dma) begin
                r_op        <= i_dma_op;
                r_info1     <= i_dma_info1[15:0];
                r_info2     <= i_dma_info2[7:0];
                r_mem_info1 <= i_dma_mem_info1;
                r_mem_info2 <= i_dma_mem_info2;
            end
            if (r_state == DECODE) begin
                r_row_addr <= w_base;
                r_rem      <= w_row_len;
                r_seg_off  <= '0;
                r_row_cnt  <= '0;
            end
            // a finished row with rows left rewinds the segment and steps one stride
            if ((r_state == WAIT) && i_mem_done) begin
                if ((w_rem_next == 16'd0) && w_more_rows) begin
                    r_row_addr <= r_row_addr + ADDR_W'(ROW_STRIDE);
                    r_row_cnt  <= r_row_cnt + 8'd1;
                    r_rem      <= w_row_len;
                    r_seg_off  <= '0;
                end else begin
                    r_rem     <= w_rem_next;
                    r_seg_off <= r_seg_off + w_len;
                end
            end
            if ((i_s_dma && o_busy) || (i_mem_done && (r_state != WAIT)) || ((r_state == DECODE) && w_illegal))
                r_err <= 1'b1;
        end
    end
endmodule
